// File: rtl/pet_pkg.sv
// Shared encodings for the virtual-pet game-state core: life states,
// action codes and the default stat width.
package pet_pkg;

    localparam int STAT_W_DEF = 4;

    localparam logic [1:0] ST_AWAKE = 2'd0;
    localparam logic [1:0] ST_SLEEP = 2'd1;
    localparam logic [1:0] ST_SICK  = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    localparam logic [2:0] ACT_FEED  = 3'd0;
    localparam logic [2:0] ACT_PLAY  = 3'd1;
    localparam logic [2:0] ACT_SLEEP = 3'd2;
    localparam logic [2:0] ACT_WAKE  = 3'd3;
    localparam logic [2:0] ACT_CURE  = 3'd4;

endpackage

// File: rtl/toggle_sync.sv
// Brings a slow toggle from the clock generator into the clkin domain and
// turns every level change into a single-cycle pulse.
module toggle_sync (
    input  logic clkin,
    input  logic rst,
    input  logic i_tog,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_p;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_p  <= 1'b0;
        end else begin
            r_s1 <= i_tog;
            r_s2 <= r_s1;
            r_p  <= r_s2;
        end
    end

    assign o_pulse = r_s2 ^ r_p;

endmodule

// File: rtl/pet_stats.sv
// Virtual-pet game state: needs, health, life state and age, driven by game
// ticks, seconds and user actions taken over a valid/ready handshake.
module pet_stats
    import pet_pkg::*;
#(
    parameter int STAT_W      = STAT_W_DEF,
    parameter int SAT_PERIOD  = 4,
    parameter int FUN_PERIOD  = 3,
    parameter int NRG_PERIOD  = 5,
    parameter int SICK_TH     = 3,
    parameter int BOOST       = 4,
    parameter int SLEEP_MAX_S = 20
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              tick_v,
    input  logic              tick_1s,
    input  logic              act_valid,
    input  logic [2:0]        act_code,
    output logic              act_ready,
    output logic [STAT_W-1:0] satiety,
    output logic [STAT_W-1:0] fun,
    output logic [STAT_W-1:0] energy,
    output logic [STAT_W-1:0] health,
    output logic [1:0]        pet_state,
    output logic [15:0]       age_s,
    output logic              alarm
);

    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam int SAT_CW = $clog2(SAT_PERIOD + 1);
    localparam int FUN_CW = $clog2(FUN_PERIOD + 1);
    localparam int NRG_CW = $clog2(NRG_PERIOD + 1);
    localparam int SLP_W  = $clog2(SLEEP_MAX_S + 1);
    localparam logic [SAT_CW-1:0] SAT_LAST = SAT_CW'(SAT_PERIOD - 1);
    localparam logic [FUN_CW-1:0] FUN_LAST = FUN_CW'(FUN_PERIOD - 1);
    localparam logic [NRG_CW-1:0] NRG_LAST = NRG_CW'(NRG_PERIOD - 1);
    localparam logic [SLP_W-1:0]  SLP_LIM  = SLP_W'(SLEEP_MAX_S);
    localparam logic [STAT_W-1:0] SICK_LIM = STAT_W'(SICK_TH);
    localparam logic [STAT_W:0]   BOOST_W  = (STAT_W + 1)'(BOOST);
    localparam logic [STAT_W:0]   ONE_W    = (STAT_W + 1)'(1);

    function automatic logic [STAT_W-1:0] f_add(input logic [STAT_W-1:0] a,
                                                 input logic [STAT_W:0]   b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + b;
        return s[STAT_W] ? STAT_MAX : s[STAT_W-1:0];
    endfunction

    function automatic logic [STAT_W-1:0] f_dec(input logic [STAT_W-1:0] a);
        return (a == '0) ? a : a - 1'b1;
    endfunction

    logic w_tick;
    logic w_sec;
    logic w_acc;

    logic [STAT_W-1:0] r_sat, r_fun, r_nrg, r_hlt;
    logic [SAT_CW-1:0] r_sat_cnt;
    logic [FUN_CW-1:0] r_fun_cnt;
    logic [NRG_CW-1:0] r_nrg_cnt;
    logic [SLP_W-1:0]  r_slp;
    logic [15:0]       r_age;
    logic [1:0]        r_state;
    logic              r_alarm;

    logic [STAT_W-1:0] w_sat_n, w_fun_n, w_nrg_n, w_hlt_n;
    logic [SAT_CW-1:0] w_sat_cnt_n;
    logic [FUN_CW-1:0] w_fun_cnt_n;
    logic [NRG_CW-1:0] w_nrg_cnt_n;
    logic [SLP_W-1:0]  w_slp_n;
    logic [15:0]       w_age_n;
    logic [1:0]        w_state_n;
    logic              w_alarm_n;

    toggle_sync u_sync_tick (
        .clkin   (clkin),
        .rst     (rst),
        .i_tog   (tick_v),
        .o_pulse (w_tick)
    );

    toggle_sync u_sync_sec (
        .clkin   (clkin),
        .rst     (rst),
        .i_tog   (tick_1s),
        .o_pulse (w_sec)
    );

    // Ready drops only on a tick cycle, so a held action simply waits one cycle.
    assign act_ready = (r_state != ST_DEAD) & ~w_tick;
    assign w_acc     = act_valid & act_ready;

    // Updates are layered in order: tick, then action, then seconds, then state.
    always_comb begin
        w_sat_n     = r_sat;
        w_fun_n     = r_fun;
        w_nrg_n     = r_nrg;
        w_hlt_n     = r_hlt;
        w_sat_cnt_n = r_sat_cnt;
        w_fun_cnt_n = r_fun_cnt;
        w_nrg_cnt_n = r_nrg_cnt;
        w_slp_n     = r_slp;
        w_age_n     = r_age;
        w_state_n   = r_state;
        if (r_state != ST_DEAD) begin
            if (w_tick) begin
                if (r_sat_cnt == SAT_LAST) begin
                    w_sat_cnt_n = '0;
                    w_sat_n     = f_dec(r_sat);
                end else begin
                    w_sat_cnt_n = r_sat_cnt + 1'b1;
                end
                if (r_state == ST_SLEEP) begin
                    w_nrg_n = f_add(r_nrg, ONE_W);
                end else begin
                    if (r_fun_cnt == FUN_LAST) begin
                        w_fun_cnt_n = '0;
                        w_fun_n     = f_dec(r_fun);
                    end else begin
                        w_fun_cnt_n = r_fun_cnt + 1'b1;
                    end
                    if (r_nrg_cnt == NRG_LAST) begin
                        w_nrg_cnt_n = '0;
                        w_nrg_n     = f_dec(r_nrg);
                    end else begin
                        w_nrg_cnt_n = r_nrg_cnt + 1'b1;
                    end
                end
                if (w_sat_n == '0 || w_fun_n == '0 || w_nrg_n == '0) begin
                    w_hlt_n = f_dec(r_hlt);
                end
            end
            if (w_acc) begin
                if (r_state == ST_SLEEP) begin
                    if (act_code == ACT_WAKE) w_state_n = ST_AWAKE;
                end else begin
                    case (act_code)
                        ACT_FEED: w_sat_n = f_add(w_sat_n, BOOST_W);
                        ACT_PLAY: begin
                            if (r_state == ST_AWAKE) begin
                                w_fun_n = f_add(w_fun_n, BOOST_W);
                                w_nrg_n = f_dec(w_nrg_n);
                            end
                        end
                        ACT_SLEEP: begin
                            if (r_state == ST_AWAKE) begin
                                w_state_n = ST_SLEEP;
                                w_slp_n   = '0;
                            end
                        end
                        ACT_CURE: w_hlt_n = f_add(w_hlt_n, BOOST_W);
                        default: ;
                    endcase
                end
            end
            if (w_sec) begin
                if (r_age != 16'hFFFF) w_age_n = r_age + 16'd1;
                if (r_state == ST_SLEEP && r_slp != '1) w_slp_n = r_slp + 1'b1;
            end
            if (w_hlt_n == '0) begin
                w_state_n = ST_DEAD;
            end else if (w_state_n == ST_SLEEP && (w_nrg_n == STAT_MAX || w_slp_n == SLP_LIM)) begin
                w_state_n = ST_AWAKE;
            end else if (w_state_n == ST_AWAKE && w_hlt_n <= SICK_LIM) begin
                w_state_n = ST_SICK;
            end else if (w_state_n == ST_SICK && w_hlt_n > SICK_LIM) begin
                w_state_n = ST_AWAKE;
            end
        end
        w_alarm_n = (w_sat_n == '0) | (w_fun_n == '0) | (w_nrg_n == '0) | (w_state_n == ST_SICK);
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_sat     <= STAT_MAX;
            r_fun     <= STAT_MAX;
            r_nrg     <= STAT_MAX;
            r_hlt     <= STAT_MAX;
            r_sat_cnt <= '0;
            r_fun_cnt <= '0;
            r_nrg_cnt <= '0;
            r_slp     <= '0;
            r_age     <= '0;
            r_state   <= ST_AWAKE;
            r_alarm   <= 1'b0;
        end else begin
            r_sat     <= w_sat_n;
            r_fun     <= w_fun_n;
            r_nrg     <= w_nrg_n;
            r_hlt     <= w_hlt_n;
            r_sat_cnt <= w_sat_cnt_n;
            r_fun_cnt <= w_fun_cnt_n;
            r_nrg_cnt <= w_nrg_cnt_n;
            r_slp     <= w_slp_n;
            r_age     <= w_age_n;
            r_state   <= w_state_n;
            r_alarm   <= w_alarm_n;
        end
    end

    assign satiety   = r_sat;
    assign fun       = r_fun;
    assign energy    = r_nrg;
    assign health    = r_hlt;
    assign pet_state = r_state;
    assign age_s     = r_age;
    assign alarm     = r_alarm;

endmodule
